// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and flag bit positions for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NA  = 4'b0110;
  localparam logic [3:0] OP_NB  = 4'b0111;
  localparam logic [3:0] OP_SQA = 4'b1000;
  localparam logic [3:0] OP_SQB = 4'b1001;
  localparam logic [3:0] OP_LT  = 4'b1010;
  localparam logic [3:0] OP_EQ  = 4'b1011;
  localparam logic [3:0] OP_GT  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_W    = 5;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_CB   = 1;
  localparam int FLAG_DZ   = 2;
  localparam int FLAG_ERR  = 3;
  localparam int FLAG_SAT  = 4;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_SQA) || (op == OP_SQB);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// W-cycle engine shared by shift-add multiply and restoring divide.
// The {hi,lo} register pair is the product in MUL mode and {remainder,quotient} in DIV mode.
module seq_alu_iter #(
  parameter int W  = 4,
  parameter int CW = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           div_mode_i,
  input  logic [W-1:0]   opa_i,
  input  logic [W-1:0]   opb_i,
  output logic [2*W-1:0] res_o,
  output logic [W-1:0]   rem_o,
  output logic           done_o
);

  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  opb_q;
  logic          div_q;
  logic          run_q;
  logic [CW-1:0] cnt_q;

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] trial;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    shifted = {hi_q, lo_q[W-1]};
    trial   = shifted - {1'b0, opb_q};
    if (div_q) begin
      // trial[W] set means the divisor did not fit: restore the shifted value
      hi_d = trial[W] ? shifted[W-1:0] : trial[W-1:0];
      lo_d = {lo_q[W-2:0], ~trial[W]};
    end else begin
      hi_d = sum[W:1];
      lo_d = {sum[0], lo_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      hi_q  <= '0;
      lo_q  <= opa_i;
      opb_q <= opb_i;
      div_q <= div_mode_i;
      run_q <= 1'b1;
      cnt_q <= CW'(W);
    end else if (run_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_q <= 1'b0;
    end
  end

  // Results come from the final step's next-state so the caller can register them on that edge.
  assign done_o = run_q && (cnt_q == CW'(1));
  assign res_o  = div_q ? {{W{1'b0}}, lo_d} : {hi_d, lo_d};
  assign rem_o  = div_q ? hi_d : '0;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: handshake FSM, single-cycle ops, result/flag registers.
// Define SEQ_ALU_SAT_EN to make ADD/SUB saturate to W bits.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// BUSY  | iterative MUL/DIV/SQA/SQB running in seq_alu_iter
// DONE  | out_valid=1, result and flags held until out_ready
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    result,
  output logic [W-1:0]      rem,
  output logic [FLAG_W-1:0] flags
);

  state_e              state_q, state_d;
  logic [2*W-1:0]      result_q, result_d;
  logic [W-1:0]        rem_q, rem_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                dz_q, dz_d;

  logic                accept;
  logic [W:0]          add_s;
  logic [2*W-1:0]      sc_res;
  logic [FLAG_W-1:0]   sc_flags;

  logic                iter_start;
  logic                iter_div;
  logic [W-1:0]        iter_a, iter_b;
  logic [2*W-1:0]      iter_res;
  logic [W-1:0]        iter_rem;
  logic                iter_done;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    sc_res   = '0;
    sc_flags = '0;
    add_s    = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD: begin
        sc_res[W:0]       = add_s;
        sc_flags[FLAG_CB] = add_s[W];
`ifdef SEQ_ALU_SAT_EN
        if (add_s[W]) begin
          sc_res             = '0;
          sc_res[W-1:0]      = '1;
          sc_flags[FLAG_SAT] = 1'b1;
        end
`endif
      end
      OP_SUB: begin
        sc_res            = {{W{1'b0}}, a} - {{W{1'b0}}, b};
        sc_flags[FLAG_CB] = (a < b);
`ifdef SEQ_ALU_SAT_EN
        if (a < b) begin
          sc_res             = '0;
          sc_flags[FLAG_SAT] = 1'b1;
        end
`endif
      end
      OP_AND: sc_res[W-1:0] = a & b;
      OP_OR:  sc_res[W-1:0] = a | b;
      OP_NA:  sc_res[W-1:0] = ~a;
      OP_NB:  sc_res[W-1:0] = ~b;
      OP_LT:  if (a < b)  sc_res = '1;
      OP_EQ:  if (a == b) sc_res = '1;
      OP_GT:  if (a > b)  sc_res = '1;
      OP_MUL, OP_DIV, OP_SQA, OP_SQB: ;
      default: sc_flags[FLAG_ERR] = 1'b1;
    endcase
    sc_flags[FLAG_ZERO] = (sc_res == '0);
  end

  // Squares reuse the multiplier with the selected operand on both inputs.
  always_comb begin
    iter_a   = a;
    iter_b   = b;
    iter_div = (op == OP_DIV);
    if (op == OP_SQA) iter_b = a;
    if (op == OP_SQB) iter_a = b;
  end

  seq_alu_iter #(.W(W), .CW(CW)) u_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (iter_start),
    .div_mode_i (iter_div),
    .opa_i      (iter_a),
    .opb_i      (iter_b),
    .res_o      (iter_res),
    .rem_o      (iter_rem),
    .done_o     (iter_done)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    rem_d      = rem_q;
    flags_d    = flags_q;
    dz_d       = dz_q;
    iter_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_iter_op(op)) begin
            state_d    = BUSY;
            iter_start = 1'b1;
            dz_d       = (op == OP_DIV) && (b == '0);
          end else begin
            state_d  = DONE;
            result_d = sc_res;
            rem_d    = '0;
            flags_d  = sc_flags;
          end
        end
      end
      BUSY: begin
        if (iter_done) begin
          state_d            = DONE;
          result_d           = iter_res;
          rem_d              = iter_rem;
          flags_d            = '0;
          flags_d[FLAG_ZERO] = (iter_res == '0);
          flags_d[FLAG_DZ]   = dz_q;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      rem_q    <= '0;
      flags_q  <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      flags_q  <= flags_d;
      dz_q     <= dz_d;
    end
  end

  assign result = result_q;
  assign rem    = rem_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed cases at W=4, random sweep at W=8.
// The reference model follows SEQ_ALU_SAT_EN when the bench is built with it.
module tb_seq_alu;

  localparam int W4 = 4;
  localparam int W8 = 8;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] res;
    logic [63:0] rem;
    logic [4:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic            in_valid_4, in_ready_4, out_valid_4, out_ready_4;
  logic [3:0]      op_4;
  logic [W4-1:0]   a_4, b_4, rem_4;
  logic [2*W4-1:0] result_4;
  logic [4:0]      flags_4;

  logic            in_valid_8, in_ready_8, out_valid_8, out_ready_8;
  logic [3:0]      op_8;
  logic [W8-1:0]   a_8, b_8, rem_8;
  logic [2*W8-1:0] result_8;
  logic [4:0]      flags_8;

  exp_t q4[$];
  exp_t q8[$];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(.W(W4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4), .op(op_4),
    .a(a_4), .b(b_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
    .result(result_4), .rem(rem_4), .flags(flags_4)
  );

  seq_alu #(.W(W8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .op(op_8),
    .a(a_8), .b(b_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
    .result(result_8), .rem(rem_8), .flags(flags_8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_iter(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd3) || (op == 4'd8) || (op == 4'd9);
  endfunction

  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [63:0] m, m2, s;
    logic sat, err, dz, cb;
    m  = (64'd1 << w) - 64'd1;
    m2 = (64'd1 << (2 * w)) - 64'd1;
    e.op = op; e.res = '0; e.rem = '0;
    sat = 1'b0; err = 1'b0; dz = 1'b0; cb = 1'b0;
    case (op)
      4'd0: begin
        s = a + b; e.res = s; cb = s[w];
`ifdef SEQ_ALU_SAT_EN
        if (s > m) begin e.res = m; sat = 1'b1; end
`endif
      end
      4'd1: begin
        e.res = (a - b) & m2; cb = (a < b);
`ifdef SEQ_ALU_SAT_EN
        if (a < b) begin e.res = '0; sat = 1'b1; end
`endif
      end
      4'd2: e.res = a * b;
      4'd3: begin
        if (b == 0) begin e.res = m; e.rem = a; dz = 1'b1; end
        else begin e.res = a / b; e.rem = a % b; end
      end
      4'd4: e.res = a & b;
      4'd5: e.res = a | b;
      4'd6: e.res = ~a & m;
      4'd7: e.res = ~b & m;
      4'd8: e.res = a * a;
      4'd9: e.res = b * b;
      4'd10: e.res = (a < b)  ? m2 : 64'd0;
      4'd11: e.res = (a == b) ? m2 : 64'd0;
      4'd12: e.res = (a > b)  ? m2 : 64'd0;
      default: err = 1'b1;
    endcase
    e.flags = {sat, err, dz, cb, (e.res == 64'd0)};
    return e;
  endfunction

  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && out_valid_4 && out_ready_4) begin
      if (q4.size() == 0) chk("unexpected_out4", 64'(out_valid_4), 64'd0);
      else begin
        e = q4.pop_front();
        chk($sformatf("res4 op=%0h", e.op), 64'(result_4), e.res);
        chk($sformatf("rem4 op=%0h", e.op), 64'(rem_4), e.rem);
        chk($sformatf("flags4 op=%0h", e.op), 64'(flags_4), 64'(e.flags));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && out_valid_8 && out_ready_8) begin
      if (q8.size() == 0) chk("unexpected_out8", 64'(out_valid_8), 64'd0);
      else begin
        e = q8.pop_front();
        chk($sformatf("res8 op=%0h", e.op), 64'(result_8), e.res);
        chk($sformatf("rem8 op=%0h", e.op), 64'(rem_8), e.rem);
        chk($sformatf("flags8 op=%0h", e.op), 64'(flags_8), 64'(e.flags));
      end
    end
  end

  initial begin
    out_ready_8 = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready_8 = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op on the W=4 unit and measure edges from accept to out_valid.
  task automatic send4(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int lat;
    int exp_lat;
    exp_lat = is_iter(op) ? W4 + 1 : 1;
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready_4), 64'd1);
    op_4 = op; a_4 = a; b_4 = b; in_valid_4 = 1'b1;
    q4.push_back(model(W4, op, 64'(a), 64'(b)));
    @(posedge clk); #1;
    in_valid_4 = 1'b0;
    op_4 = 4'($urandom); a_4 = 4'($urandom); b_4 = 4'($urandom);
    lat = 1;
    while (lat <= 40) begin
      @(negedge clk);
      if (out_valid_4) break;
      chk("in_ready_busy", 64'(in_ready_4), 64'd0);
      lat++;
    end
    chk($sformatf("latency op=%0h", op), 64'(lat), 64'(exp_lat));
  endtask

  initial begin : main
    logic [3:0] rop;
    logic [7:0] ra, rb;
    int t;
    rst = 1'b1;
    in_valid_4 = 1'b0; op_4 = '0; a_4 = '0; b_4 = '0; out_ready_4 = 1'b1;
    in_valid_8 = 1'b0; op_8 = '0; a_8 = '0; b_8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready4", 64'(in_ready_4), 64'd1);
    chk("rst_out_valid4", 64'(out_valid_4), 64'd0);
    chk("rst_result4", 64'(result_4), 64'd0);
    chk("rst_rem4", 64'(rem_4), 64'd0);
    chk("rst_flags4", 64'(flags_4), 64'd0);
    chk("rst_in_ready8", 64'(in_ready_8), 64'd1);
    chk("rst_out_valid8", 64'(out_valid_8), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send4(4'd0, 4'd9, 4'd8);
    send4(4'd2, 4'd15, 4'd15);
    send4(4'd3, 4'd13, 4'd4);
    send4(4'd3, 4'd7, 4'd0);
    send4(4'd1, 4'd3, 4'd5);
    send4(4'd9, 4'd2, 4'd11);
    send4(4'd6, 4'd5, 4'd0);
    send4(4'hE, 4'd1, 4'd2);

    // backpressure: result must hold for 10 cycles, then next op goes in right after handshake
    @(posedge clk); #1;
    out_ready_4 = 1'b0;
    send4(4'hC, 4'd5, 4'd3);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(out_valid_4), 64'd1);
      chk("bp_result", 64'(result_4), 64'hFF);
      chk("bp_in_ready", 64'(in_ready_4), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready_4 = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(out_valid_4), 64'd1);
    send4(4'd4, 4'd12, 4'd10);

    // reset in the middle of a square: no output may appear afterwards
    @(negedge clk);
    op_4 = 4'd8; a_4 = 4'd12; b_4 = 4'd0; in_valid_4 = 1'b1;
    @(posedge clk); #1;
    in_valid_4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid_4), 64'd0);
    chk("abort_in_ready", 64'(in_ready_4), 64'd1);
    chk("abort_result", 64'(result_4), 64'd0);
    for (int i = 0; i < W4 + 2; i++) begin
      @(negedge clk);
      chk("abort_no_output", 64'(out_valid_4), 64'd0);
    end
    send4(4'hB, 4'd3, 4'd3);
    send4(4'hA, 4'd3, 4'd3);

    // random sweep on the W=8 unit with random out_ready
    for (int i = 0; i < 1000; i++) begin
      t = 0;
      @(negedge clk);
      while (!in_ready_8 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        chk("in_ready_timeout8", 64'(in_ready_8), 64'd1);
        break;
      end
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      op_8 = rop; a_8 = ra; b_8 = rb; in_valid_8 = 1'b1;
      q8.push_back(model(W8, rop, 64'(ra), 64'(rb)));
      @(posedge clk); #1;
      in_valid_8 = 1'b0;
      op_8 = 4'($urandom); a_8 = 8'($urandom); b_8 = 8'($urandom);
    end

    t = 0;
    while ((q8.size() != 0 || q4.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_q8", 64'(q8.size()), 64'd0);
    chk("drain_q4", 64'(q4.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
